// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core (FSM states, opcodes, mux selects).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // Opcodes handled by this controller
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // alu_op classes, also consumed by the ALU decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // True for every opcode the FSM knows how to sequence
  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences one instruction over 3-5 cycles.
// Latency: beq 3, R/I/jal/sw 4, lw 5 cycles with memory always ready; outputs are Moore except ready/zero gating.
// Backpressure: mem_ready low holds FETCH, MEMREAD or MEMWRITE one extra cycle per low cycle.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           alu_op,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire;

  // Raw (pre-reset-gating) enables from the output decode
  logic pc_update, branch, ir_wr, reg_wr, mem_wr, ill;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic and retire detection
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) state_d = S_MEMADR;
        else if (op == OP_RTYPE)            state_d = S_EXECR;
        else if (op == OP_ITYPE)            state_d = S_EXECI;
        else if (op == OP_JAL)              state_d = S_JAL;
        else if (op == OP_BEQ)              state_d = S_BEQ;
        else                                state_d = S_FETCH;
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: if (mem_ready) begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath selects and raw enables
  always_comb begin
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    ill        = 1'b0;
    case (state_q)
      S_FETCH: begin
        result_src = RES_ALURESULT;
        alu_src_b  = SRCB_FOUR;
        ir_wr      = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        // Branch target OldPC + imm parked in ALUOut for BEQ
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        ill       = !is_legal_op(op);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_wr     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_wr  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_ALUWB:    reg_wr = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated with rst_n so they drop the instant reset asserts,
  // not at the next clock edge.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_wr;
  assign reg_write = rst_n & reg_wr;
  assign mem_write = rst_n & mem_wr;
  assign illegal   = rst_n & ill;

  // Retired-instruction counter, wraps naturally
  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + INSTRET_W'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors queued per instruction.
// Latency: each queued step is one clock; outputs sampled on the falling edge.
// Backpressure: mem_ready pattern is carried in each queued step.
module tb_multicycle_ctrl;

  localparam int RW = 4;

  localparam int K_R    = 0;
  localparam int K_I    = 1;
  localparam int K_JAL  = 2;
  localparam int K_BEQ  = 3;
  localparam int K_LW   = 4;
  localparam int K_SW   = 5;
  localparam int K_ILL  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    op = 7'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic [RW-1:0] instret;

  int n_run  = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_ret = '0;

  typedef struct {
    logic        rdy;
    logic        z;
    logic [14:0] exp;
    string       tag;
  } step_t;
  step_t sb_q[$];

  multicycle_ctrl #(.INSTRET_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src,
                alu_src_a, alu_src_b, reg_write, alu_op, illegal};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {pc_write, adr_src, mem_write, ir_write, result_src, src_a, src_b, reg_write, alu_op, illegal}
  function automatic logic [14:0] ov(input logic pcw, input logic adr, input logic mw, input logic irw,
                                     input logic [1:0] res, input logic [1:0] a, input logic [1:0] b,
                                     input logic rw, input logic [1:0] aop, input logic ill);
    return {pcw, adr, mw, irw, res, a, b, rw, aop, ill};
  endfunction

  task automatic push(input logic rdy, input logic z, input logic [14:0] e, input string tag);
    step_t s;
    s.rdy = rdy; s.z = z; s.exp = e; s.tag = tag;
    sb_q.push_back(s);
  endtask

  // Entered just after a rising edge; one queued step per clock
  task automatic drain();
    step_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy;
      zero      = s.z;
      @(negedge clk);
      chk_eq(s.tag, {17'b0, obs}, {17'b0, s.exp});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_fetch(input string nm, input int fw);
    for (int i = 0; i < fw; i++)
      push(1'b0, 1'b0, ov(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00,0), {nm, ":fetch_wait"});
    push(1'b1, 1'b0, ov(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,0), {nm, ":fetch"});
  endtask

  task automatic run_instr(input string nm, input int kind, input logic [6:0] opc,
                           input int fw, input int mw, input logic z);
    op = opc;
    push_fetch(nm, fw);
    push(1'b1, z, ov(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,(kind == K_ILL)), {nm, ":decode"});
    case (kind)
      K_R: begin
        push(1'b1, z, ov(0,0,0,0,2'b00,2'b10,2'b00,0,2'b10,0), {nm, ":execr"});
        push(1'b1, z, ov(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,0), {nm, ":aluwb"});
      end
      K_I: begin
        push(1'b1, z, ov(0,0,0,0,2'b00,2'b10,2'b01,0,2'b10,0), {nm, ":execi"});
        push(1'b1, z, ov(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,0), {nm, ":aluwb"});
      end
      K_JAL: begin
        push(1'b1, z, ov(1,0,0,0,2'b00,2'b01,2'b10,0,2'b00,0), {nm, ":jal"});
        push(1'b1, z, ov(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,0), {nm, ":aluwb"});
      end
      K_BEQ:
        push(1'b1, z, ov(z,0,0,0,2'b00,2'b10,2'b00,0,2'b01,0), {nm, ":beq"});
      K_LW: begin
        push(1'b1, z, ov(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,0), {nm, ":memadr"});
        for (int i = 0; i < mw; i++)
          push(1'b0, z, ov(0,1,0,0,2'b00,2'b00,2'b00,0,2'b00,0), {nm, ":memread_wait"});
        push(1'b1, z, ov(0,1,0,0,2'b00,2'b00,2'b00,0,2'b00,0), {nm, ":memread"});
        push(1'b1, z, ov(0,0,0,0,2'b01,2'b00,2'b00,1,2'b00,0), {nm, ":memwb"});
      end
      K_SW: begin
        push(1'b1, z, ov(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,0), {nm, ":memadr"});
        for (int i = 0; i < mw; i++)
          push(1'b0, z, ov(0,1,1,0,2'b00,2'b00,2'b00,0,2'b00,0), {nm, ":memwrite_wait"});
        push(1'b1, z, ov(0,1,1,0,2'b00,2'b00,2'b00,0,2'b00,0), {nm, ":memwrite"});
      end
      default: ;
    endcase
    drain();
    if (kind != K_ILL) exp_ret = exp_ret + 1'b1;
    chk_eq({nm, ":instret"}, 32'(instret), 32'(exp_ret));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while rst_n low, mem_ready high
    #12;
    chk_eq("rst:ir_write",   32'(ir_write),   32'd0);
    chk_eq("rst:pc_write",   32'(pc_write),   32'd0);
    chk_eq("rst:instret",    32'(instret),    32'd0);
    chk_eq("rst:alu_src_b",  32'(alu_src_b),  32'd2);
    chk_eq("rst:result_src", 32'(result_src), 32'd2);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr("rtype",     K_R,   7'b0110011, 0, 0, 1'b0);
    run_instr("rtype_fw",  K_R,   7'b0110011, 2, 0, 1'b0);
    run_instr("lw",        K_LW,  7'b0000011, 0, 2, 1'b0);
    run_instr("lw_fast",   K_LW,  7'b0000011, 0, 0, 1'b1);
    run_instr("sw",        K_SW,  7'b0100011, 0, 3, 1'b0);
    run_instr("beq_z1",    K_BEQ, 7'b1100011, 0, 0, 1'b1);
    run_instr("beq_z0",    K_BEQ, 7'b1100011, 0, 0, 1'b0);
    run_instr("itype",     K_I,   7'b0010011, 0, 0, 1'b0);
    run_instr("jal",       K_JAL, 7'b1101111, 1, 0, 1'b0);
    run_instr("illegal",   K_ILL, 7'b1111111, 0, 0, 1'b0);
    run_instr("illegal2",  K_ILL, 7'b0000000, 0, 0, 1'b1);

    // Reset asserted mid-EXECR: enables drop at once, counter clears
    op = 7'b0110011;
    push_fetch("rstmid", 0);
    push(1'b1, 1'b0, ov(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,0), "rstmid:decode");
    drain();
    @(negedge clk);
    chk_eq("rstmid:execr_alu_op", 32'(alu_op), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rstmid:reg_write", 32'(reg_write), 32'd0);
    chk_eq("rstmid:instret",   32'(instret),   32'd0);
    chk_eq("rstmid:alu_src_b", 32'(alu_src_b), 32'd2);
    chk_eq("rstmid:ir_write_in_rst", 32'(ir_write), 32'd0);
    exp_ret = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("rstmid:ir_write_after", 32'(ir_write), 32'd1);
    @(posedge clk);
    #1;
    // The abandoned slot decodes as illegal so nothing retires
    op = 7'b1111111;
    push(1'b1, 1'b0, ov(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,1), "rstmid:decode_ill");
    drain();
    chk_eq("rstmid:instret_after", 32'(instret), 32'd0);

    // Bring the counter to all-ones, then one more retire must wrap to zero
    for (int i = 0; i < 64 && exp_ret != '1; i++)
      run_instr("fill", K_BEQ, 7'b1100011, 0, 0, 1'b0);
    chk_eq("wrap:all_ones", 32'(instret), 32'((1 << RW) - 1));
    run_instr("wrap", K_R, 7'b0110011, 0, 0, 1'b0);
    chk_eq("wrap:zero", 32'(instret), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
